mux_serial_sequencer: RTL and testbench
=======================================

# mux_serial_sequencer

Byte-to-bit sequencer that sits directly upstream of the 8:1 bit multiplexer. It accepts an 8-bit word over a valid/ready handshake and holds it on the multiplexer data inputs. It then steps the 3-bit select through all eight positions, holding each for a programmable number of cycles, so the multiplexer output becomes a serial bit stream. Framing strobes let the downstream consumer sample each bit and detect word boundaries.

## Interface
Parameters:
- DIV, default 4: clock cycles each bit is held on the multiplexer output; legal range 1..65535.
- DIV_W, default 16: width of the internal hold counter; must satisfy 2**DIV_W > DIV.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  8  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  sequencer can accept a word this cycle.
- mux_i  output  8  registered word driven to the multiplexer data inputs.
- mux_s  output  3  registered select driven to the multiplexer select inputs.
- bit_strobe  output  1  high in the first cycle of every bit period.
- bit_last  output  1  high for the whole eighth bit period.
- busy  output  1  high while a word is being sequenced.

## Operation
- States: IDLE and SHIFT.
- Reset (rst high at an edge):
  - State goes to IDLE; mux_i=8'h00; mux_s=3'd0; bit_strobe=0; bit_last=0; busy=0.
  - Hold counter and bit counter clear.
  - in_ready is forced 0 while rst is high.
  - Reset mid-word discards the word; no further strobes follow.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: mux_i<=in_data; mux_s<=first index; hold counter<=0; bit counter<=0; go to SHIFT.
  - mux_i and mux_s otherwise hold their last values.
- SHIFT:
  - busy=1.
  - The hold counter counts 0..DIV-1.
  - When the hold counter reaches DIV-1 and the bit counter is below 7: the bit counter increments, mux_s advances one index, and the hold counter returns to 0.
  - When the hold counter reaches DIV-1 and the bit counter is 7 (final cycle of the word):
    - in_ready=1.
    - If in_valid is high, load the new word and restart at the first index, staying in SHIFT. Output is gapless.
    - Otherwise go to IDLE.
- in_valid is ignored whenever in_ready=0.
- in_data is sampled only at the accepting edge; later changes have no effect.
- bit_strobe is 1 when the hold counter is 0 in SHIFT.
- bit_last is 1 when the bit counter is 7 in SHIFT.
- Index order: ascending 0,1,...,7 by default (LSB first). See Configuration.

## Timing
- Accept edge at cycle N: mux_i, mux_s and busy are valid from cycle N+1, with bit_strobe=1 in cycle N+1.
- Each bit is held for exactly DIV cycles. A word occupies 8*DIV cycles.
- Back-to-back words: the first bit of word k+1 appears in the cycle immediately after the last cycle of word k.
- Idle gap: if in_valid is low in the final cycle, busy drops to 0 the next cycle. mux_i and mux_s hold their values.
- DIV=1: bit_strobe stays high every SHIFT cycle; the select changes every cycle; in_ready is high only in the cycle where bit_last is high.
- All outputs except in_ready are registered.
- in_ready is combinational from state and counters only. It never depends on in_valid.

## Configuration
- Macro SER_MSB_FIRST_EN.
- Defined: the first index is 3'd7 and mux_s decrements 7,6,...,0 (MSB first).
- Undefined: the first index is 3'd0 and mux_s increments 0,1,...,7 (LSB first).
- Reset value of mux_s is 3'd0 in both builds.
- Counter, strobe and handshake timing are identical in both builds.

## Test plan
- Reset: hold rst high 3 cycles with in_valid=1 and in_data=8'hFF.
  - Required: in_ready=0; all outputs 0. After release, in_ready=1 and busy=0.
- Single word, DIV=4, in_data=8'hA5, LSB-first build:
  - mux_s steps 0..7, 4 cycles per step; mux_i=8'hA5 throughout.
  - bit_strobe pulses 8 times, 4 cycles apart.
  - bit_last is high for cycles 29..32 after the accept edge.
  - busy falls after 32 cycles.
- Back-to-back, DIV=2: words 8'h3C then 8'hC3, with in_valid held high.
  - Second accept happens in the final cycle of the first word.
  - mux_s goes 7 then 0 on consecutive cycles with no idle cycle.
- Word arriving mid-word: in_valid=1 with 8'h11 during the third bit of a word.
  - Not accepted; in_ready=0 and mux_i is unchanged.
  - Accepted at the final cycle of the word.
- DIV=1, SER_MSB_FIRST_EN defined, in_data=8'h80:
  - mux_s goes 7,6,...,0 on 8 consecutive cycles.
  - bit_strobe is high all 8 cycles; bit_last is high only on the cycle with mux_s=0.
- Reset mid-word: assert rst during bit 5.
  - Next cycle: busy=0, mux_s=0, mux_i=8'h00; no further strobes.
  - A new word is accepted normally after release.

Source files
------------

// File: rtl/mux_serial_sequencer.sv
// -----------------------------------------------------------------------------
// mux_serial_sequencer
//
// Byte-to-bit sequencer feeding an 8:1 bit multiplexer. A word accepted over a
// valid/ready handshake is held on the multiplexer data inputs (mux_i) while the
// select (mux_s) walks through all eight positions, each held for DIV cycles.
// The multiplexer output therefore becomes a serial bit stream. bit_strobe
// marks the first cycle of every bit period; bit_last marks the whole final
// bit period so the consumer can find word boundaries.
//
// Build option:
//   SER_MSB_FIRST_EN  defined   -> select order 7,6,...,0 (MSB first)
//                     undefined -> select order 0,1,...,7 (LSB first)
//
// Parameters:
//   DIV    cycles each bit is held (1..65535)
//   DIV_W  width of the hold counter, 2**DIV_W > DIV
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   in_data     word to serialize
//   in_valid    in_data is valid
//   in_ready    a word can be accepted this cycle (combinational)
//   mux_i       registered word for the multiplexer data inputs
//   mux_s       registered multiplexer select
//   bit_strobe  first cycle of each bit period
//   bit_last    high through the eighth bit period
//   busy        a word is being sequenced
// -----------------------------------------------------------------------------
module mux_serial_sequencer #(
    parameter int DIV   = 4,
    parameter int DIV_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] mux_i,
    output logic [2:0] mux_s,
    output logic       bit_strobe,
    output logic       bit_last,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Last value of the hold counter within one bit period.
    localparam logic [DIV_W-1:0] HOLD_MAX = DIV_W'(DIV - 1);

`ifdef SER_MSB_FIRST_EN
    localparam logic [2:0] FIRST_IDX = 3'd7;
`else
    localparam logic [2:0] FIRST_IDX = 3'd0;
`endif

    state_t           state_reg,      state_next;
    logic [DIV_W-1:0] hold_cnt_reg,   hold_cnt_next;
    logic [2:0]       bit_cnt_reg,    bit_cnt_next;
    logic [7:0]       mux_i_reg,      mux_i_next;
    logic [2:0]       mux_s_reg,      mux_s_next;
    logic             bit_strobe_reg, bit_strobe_next;
    logic             bit_last_reg,   bit_last_next;
    logic             busy_reg,       busy_next;

    logic             word_end;
    logic             ready_int;
    logic             accept;
    logic [2:0]       step_idx;

    // Final cycle of the eighth bit period: the only SHIFT cycle that can
    // take a new word, which is what makes back-to-back output gapless.
    assign word_end = (state_reg == SHIFT) &&
                      (hold_cnt_reg == HOLD_MAX) &&
                      (bit_cnt_reg == 3'd7);

    // Depends only on state/counters (and reset), never on in_valid.
    assign ready_int = !rst && ((state_reg == IDLE) || word_end);
    assign in_ready  = ready_int;
    assign accept    = in_valid && ready_int;

    // Select index following the current one in the configured order.
`ifdef SER_MSB_FIRST_EN
    assign step_idx = mux_s_reg - 3'd1;
`else
    assign step_idx = mux_s_reg + 3'd1;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        mux_i_next    = mux_i_reg;
        mux_s_next    = mux_s_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next    = SHIFT;
                    mux_i_next    = in_data;
                    mux_s_next    = FIRST_IDX;
                    hold_cnt_next = '0;
                    bit_cnt_next  = 3'd0;
                end
            end

            SHIFT: begin
                if (hold_cnt_reg == HOLD_MAX) begin
                    hold_cnt_next = '0;
                    if (bit_cnt_reg == 3'd7) begin
                        if (accept) begin
                            // Restart immediately with the new word.
                            mux_i_next   = in_data;
                            mux_s_next   = FIRST_IDX;
                            bit_cnt_next = 3'd0;
                        end else begin
                            // mux_i/mux_s keep the last word's values.
                            state_next = IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        mux_s_next   = step_idx;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + DIV_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Framing outputs are registered: derive them from the values the
        // state and counters take after this edge.
        busy_next       = (state_next == SHIFT);
        bit_strobe_next = (state_next == SHIFT) && (hold_cnt_next == '0);
        bit_last_next   = (state_next == SHIFT) && (bit_cnt_next == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            hold_cnt_reg   <= '0;
            bit_cnt_reg    <= 3'd0;
            mux_i_reg      <= 8'h00;
            mux_s_reg      <= 3'd0;
            bit_strobe_reg <= 1'b0;
            bit_last_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            mux_i_reg      <= mux_i_next;
            mux_s_reg      <= mux_s_next;
            bit_strobe_reg <= bit_strobe_next;
            bit_last_reg   <= bit_last_next;
            busy_reg       <= busy_next;
        end
    end

    assign mux_i      = mux_i_reg;
    assign mux_s      = mux_s_reg;
    assign bit_strobe = bit_strobe_reg;
    assign bit_last   = bit_last_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_mux_serial_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_serial_sequencer
//
// Three sequencer instances (DIV = 4, 2, 1) share clock and reset. A
// word-timeline reference model (cycles since accept, bit = t/DIV,
// phase = t%DIV) predicts every output of every instance each cycle.
// A vector table covers reset and a single DIV=4 word; hand-written sequences
// cover back-to-back words, a word offered mid-word, DIV=1 and reset mid-word;
// a random phase finishes the run. Follows SER_MSB_FIRST_EN like the design.
// -----------------------------------------------------------------------------
module tb_mux_serial_sequencer;

    localparam int N = 3;

    logic       clk;
    logic       rst;
    logic [7:0] in_data    [N];
    logic       in_valid   [N];
    logic       in_ready   [N];
    logic [7:0] mux_i      [N];
    logic [2:0] mux_s      [N];
    logic       bit_strobe [N];
    logic       bit_last   [N];
    logic       busy       [N];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    // Select index of bit k of a word in this build.
    function automatic logic [2:0] idx(input int k);
`ifdef SER_MSB_FIRST_EN
        return 3'(7 - k);
`else
        return 3'(k);
`endif
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            localparam int D = (gi == 0) ? 4 : ((gi == 1) ? 2 : 1);
            mux_serial_sequencer #(.DIV(D), .DIV_W(16)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_data    (in_data[gi]),
                .in_valid   (in_valid[gi]),
                .in_ready   (in_ready[gi]),
                .mux_i      (mux_i[gi]),
                .mux_s      (mux_s[gi]),
                .bit_strobe (bit_strobe[gi]),
                .bit_last   (bit_last[gi]),
                .busy       (busy[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per instance, whether a word is active, cycles since
    // its accept edge, the held word and the held select.
    logic       m_active [N];
    int         m_t      [N];
    logic [7:0] m_word   [N];
    logic [2:0] m_s      [N];
    logic       rdy_pre  [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check in_ready before the edge, advance the model at
    // the edge, check all registered outputs just after it.
    task automatic step();
        logic       r;
        logic       v  [N];
        logic [7:0] d  [N];
        logic       er [N];
        int         dv;
        #1;
        r = rst;
        for (int i = 0; i < N; i++) begin
            dv = div_of(i);
            v[i]  = in_valid[i];
            d[i]  = in_data[i];
            er[i] = !r && (!m_active[i] || (m_t[i] == 8 * dv - 1));
            rdy_pre[i] = in_ready[i];
            chk($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(er[i]));
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            dv = div_of(i);
            if (r) begin
                m_active[i] = 1'b0;
                m_t[i]      = 0;
                m_word[i]   = 8'h00;
                m_s[i]      = 3'd0;
            end else if (er[i] && v[i]) begin
                m_active[i] = 1'b1;
                m_t[i]      = 0;
                m_word[i]   = d[i];
            end else if (m_active[i]) begin
                if (m_t[i] == 8 * dv - 1) m_active[i] = 1'b0;
                else                      m_t[i]++;
            end
            if (m_active[i]) m_s[i] = idx(m_t[i] / dv);
        end
        #1;
        for (int i = 0; i < N; i++) begin
            dv = div_of(i);
            chk($sformatf("busy%0d", i),  32'(busy[i]),  32'(m_active[i]));
            chk($sformatf("mux_s%0d", i), 32'(mux_s[i]), 32'(m_s[i]));
            chk($sformatf("mux_i%0d", i), 32'(mux_i[i]), 32'(m_word[i]));
            chk($sformatf("bit_strobe%0d", i), 32'(bit_strobe[i]),
                32'(m_active[i] && (m_t[i] % dv == 0)));
            chk($sformatf("bit_last%0d", i), 32'(bit_last[i]),
                32'(m_active[i] && (m_t[i] / dv == 7)));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < N; i++) in_valid[i] = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       e_ready;
        logic       e_busy;
        logic [2:0] e_s;
        logic       e_strobe;
        logic       e_last;
        logic [7:0] e_i;
    } vec_t;

    initial begin
        vec_t       tbl [$];
        vec_t       row;
        int         n;
        logic       acc;
        logic [2:0] prev_s;

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = 8'h00;
            m_active[i] = 1'b0;
            m_t[i]      = 0;
            m_word[i]   = 8'h00;
            m_s[i]      = 3'd0;
            rdy_pre[i]  = 1'b0;
        end

        // ---- vector table: reset with valid high, then one DIV=4 word ----
        for (int k = 0; k < 3; k++) begin
            row = '{rst:1'b1, v:1'b1, d:8'hFF, e_ready:1'b0, e_busy:1'b0,
                    e_s:3'd0, e_strobe:1'b0, e_last:1'b0, e_i:8'h00};
            tbl.push_back(row);
        end
        // c = cycle after the accept edge observed after this row's edge.
        for (int c = 1; c <= 34; c++) begin
            row.rst      = 1'b0;
            row.v        = (c == 1);
            row.d        = (c == 1) ? 8'hA5 : 8'h5A;
            row.e_ready  = (c == 1) || (c == 33) || (c == 34);
            row.e_busy   = (c <= 32);
            row.e_s      = (c <= 32) ? idx((c - 1) / 4) : idx(7);
            row.e_strobe = (c <= 32) && ((c - 1) % 4 == 0);
            row.e_last   = (c >= 29) && (c <= 32);
            row.e_i      = 8'hA5;
            tbl.push_back(row);
        end
        foreach (tbl[j]) begin
            rst         = tbl[j].rst;
            in_valid[0] = tbl[j].v;
            in_data[0]  = tbl[j].d;
            step();
            chk($sformatf("tbl%0d_ready", j),  32'(rdy_pre[0]),    32'(tbl[j].e_ready));
            chk($sformatf("tbl%0d_busy", j),   32'(busy[0]),       32'(tbl[j].e_busy));
            chk($sformatf("tbl%0d_mux_s", j),  32'(mux_s[0]),      32'(tbl[j].e_s));
            chk($sformatf("tbl%0d_strobe", j), 32'(bit_strobe[0]), 32'(tbl[j].e_strobe));
            chk($sformatf("tbl%0d_last", j),   32'(bit_last[0]),   32'(tbl[j].e_last));
            chk($sformatf("tbl%0d_mux_i", j),  32'(mux_i[0]),      32'(tbl[j].e_i));
        end
        idle(2);

        // ---- back-to-back words, DIV=2 ----
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h3C;
        step();
        chk("b2b_first_accept", 32'(rdy_pre[1]), 32'd1);
        in_data[1] = 8'hC3;
        n = 0;
        acc = 1'b0;
        prev_s = mux_s[1];
        while (!acc && n < 40) begin
            prev_s = mux_s[1];
            step();
            n++;
            if (rdy_pre[1]) acc = 1'b1;
        end
        chk("b2b_accept_cycle", 32'(n), 32'd16);
        chk("b2b_prev_s", 32'(prev_s), 32'(idx(7)));
        chk("b2b_next_s", 32'(mux_s[1]), 32'(idx(0)));
        chk("b2b_mux_i", 32'(mux_i[1]), 32'hC3);
        chk("b2b_busy", 32'(busy[1]), 32'd1);
        chk("b2b_strobe", 32'(bit_strobe[1]), 32'd1);
        idle(20);

        // ---- word offered mid-word, DIV=4 ----
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h5A;
        step();
        in_valid[0] = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("mid_third_bit_s", 32'(mux_s[0]), 32'(idx(2)));
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h11;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 60) begin
            step();
            n++;
            if (rdy_pre[0]) acc = 1'b1;
            else chk("mid_mux_i_held", 32'(mux_i[0]), 32'h5A);
        end
        chk("mid_accept_cycle", 32'(n), 32'd24);
        chk("mid_new_mux_i", 32'(mux_i[0]), 32'h11);
        idle(40);

        // ---- DIV=1 single word ----
        in_valid[2] = 1'b1;
        in_data[2]  = 8'h80;
        step();
        in_valid[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("div1_s%0d", k), 32'(mux_s[2]), 32'(idx(k)));
            chk($sformatf("div1_strobe%0d", k), 32'(bit_strobe[2]), 32'd1);
            chk($sformatf("div1_last%0d", k), 32'(bit_last[2]), 32'(k == 7));
            chk($sformatf("div1_mux_i%0d", k), 32'(mux_i[2]), 32'h80);
            step();
            chk($sformatf("div1_ready%0d", k), 32'(rdy_pre[2]), 32'(k == 7));
        end
        chk("div1_done_busy", 32'(busy[2]), 32'd0);
        idle(2);

        // ---- reset mid-word, DIV=4 ----
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hE7;
        step();
        in_valid[0] = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("rstmid_bit5_s", 32'(mux_s[0]), 32'(idx(5)));
        rst = 1'b1;
        step();
        chk("rstmid_busy", 32'(busy[0]), 32'd0);
        chk("rstmid_mux_s", 32'(mux_s[0]), 32'd0);
        chk("rstmid_mux_i", 32'(mux_i[0]), 32'h00);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("rstmid_no_strobe", 32'(bit_strobe[0]), 32'd0);
        end
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h77;
        step();
        chk("rstmid_reaccept_busy", 32'(busy[0]), 32'd1);
        chk("rstmid_reaccept_mux_i", 32'(mux_i[0]), 32'h77);
        idle(40);

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                in_valid[i] = ($urandom_range(0, 3) != 0);
                in_data[i]  = 8'($urandom);
            end
            step();
        end
        rst = 1'b0;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
